// File: rtl/ov7670_pkg.sv
// Shared types and constants for the synthetic OV7670 stream generator
// and the capture-side benches that consume its output.
package ov7670_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBP    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFP    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    MODE_BARS    = 2'd0,
    MODE_CHECKER = 2'd1,
    MODE_RAMP    = 2'd2,
    MODE_SOLID   = 2'd3
  } mode_e;

  // VGA timing in the sensor's native units (pixels / lines)
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_TOTAL  = 784;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP     = 17;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;

  // Width of the pixel and line counters; covers H_TOTAL and every line count
  localparam int CNT_W = 12;

  // Colour-bar palette, index 0 is the left-most bar
  localparam logic [7:0][11:0] BAR_RGB = {
    12'h000, 12'h00F, 12'hF00, 12'hF0F,
    12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
  };

  // RGB444 byte split: first byte carries R in the low nibble, second {G,B}
  function automatic logic [7:0] rgb444_byte(input logic [11:0] rgb, input logic ph);
    return ph ? rgb[7:0] : {4'h0, rgb[11:8]};
  endfunction

endpackage

// File: rtl/ov7670_stream_gen_pixel.sv
// Combinational test-pattern source: pixel position, pattern mode and the
// solid colour in, one RGB444 pixel out.
module stream_pattern_pixel
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE
) (
  input  logic [CNT_W-1:0] x,
  input  logic [CNT_W-1:0] y,
  input  mode_e            mode,
  input  logic [11:0]      solid,
  output logic [11:0]      rgb
);

  // Guard against a degenerate narrow line so the divisor is never zero
  localparam int BAR_W = ((H_ACTIVE / 8) > 0) ? (H_ACTIVE / 8) : 1;

  logic [CNT_W-1:0] bar_idx;
  logic             y_unused;

  assign bar_idx  = x / CNT_W'(BAR_W);
  // Only y[5] feeds the checker; the remaining row bits are intentionally ignored
  assign y_unused = ^{y[CNT_W-1:6], y[4:0]};

  // Select the pixel colour for the current pattern
  always_comb begin
    rgb = 12'h000;
    case (mode)
      MODE_BARS:    rgb = (bar_idx < CNT_W'(8)) ? BAR_RGB[bar_idx[2:0]] : 12'h000;
      MODE_CHECKER: rgb = (x[5] ^ y[5]) ? 12'hFFF : 12'h000;
      MODE_RAMP:    rgb = {3{x[9:6]}};
      MODE_SOLID:   rgb = solid;
      default:      rgb = 12'h000;
    endcase
  end

endmodule

// File: rtl/ov7670_stream_gen.sv
// Synthetic OV7670 transmitter: VGA frame timing with RGB444 two-byte pixels
// on vsync/href/data. Outputs are registered one pclk behind the counters, so
// href, vsync and data always move together.
module ov7670_stream_gen
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [11:0] solid_rgb,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] VSYNC_LAST = CNT_W'(V_SYNC - 1);
  localparam logic [CNT_W-1:0] VBP_LAST   = CNT_W'(V_BP - 1);
  localparam logic [CNT_W-1:0] VACT_LAST  = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] VFP_LAST   = CNT_W'(V_FP - 1);

  state_e           state_q, state_d;
  logic             byte_ph_q, byte_ph_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;
  mode_e            mode_q, mode_d;
  logic [11:0]      solid_q, solid_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             vsync_q, vsync_d;
  logic             href_q, href_d;
  logic [7:0]       data_q, data_d;
  logic             frame_start_q, frame_start_d;

  logic [CNT_W-1:0] vlast;
  logic             line_end;
  logic             state_end;
  logic [11:0]      pix_rgb;

  stream_pattern_pixel #(
    .H_ACTIVE (H_ACTIVE)
  ) u_pixel (
    .x     (hcnt_q),
    .y     (vcnt_q),
    .mode  (mode_q),
    .solid (solid_q),
    .rgb   (pix_rgb)
  );

  // State, counters, latched pattern settings and output registers
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      byte_ph_q     <= 1'b0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      mode_q        <= MODE_BARS;
      solid_q       <= 12'h000;
      frame_cnt_q   <= 8'h00;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      data_q        <= 8'h00;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_ph_q     <= byte_ph_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      mode_q        <= mode_d;
      solid_q       <= solid_d;
      frame_cnt_q   <= frame_cnt_d;
      vsync_q       <= vsync_d;
      href_q        <= href_d;
      data_q        <= data_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Next state: byte/pixel/line counting and frame sequencing
  always_comb begin
    state_d     = state_q;
    byte_ph_d   = byte_ph_q;
    hcnt_d      = hcnt_q;
    vcnt_d      = vcnt_q;
    mode_d      = mode_q;
    solid_d     = solid_q;
    frame_cnt_d = frame_cnt_q;

    vlast = '0;
    case (state_q)
      ST_VSYNC:  vlast = VSYNC_LAST;
      ST_VBP:    vlast = VBP_LAST;
      ST_ACTIVE: vlast = VACT_LAST;
      ST_VFP:    vlast = VFP_LAST;
      default:   vlast = '0;
    endcase
    line_end  = byte_ph_q && (hcnt_q == H_LAST);
    state_end = line_end && (vcnt_q == vlast);

    if (state_q == ST_IDLE) begin
      byte_ph_d = 1'b0;
      hcnt_d    = '0;
      vcnt_d    = '0;
      if (enable) state_d = ST_VSYNC;
    end else begin
      byte_ph_d = ~byte_ph_q;
      if (byte_ph_q) hcnt_d = line_end ? '0 : hcnt_q + 1'b1;
      if (line_end)  vcnt_d = state_end ? '0 : vcnt_q + 1'b1;
      if (state_end) begin
        case (state_q)
          ST_VSYNC:  state_d = ST_VBP;
          ST_VBP:    state_d = ST_ACTIVE;
          ST_ACTIVE: state_d = ST_VFP;
          ST_VFP: begin
            // Enable is only consulted here, so a frame always runs to completion
            frame_cnt_d = frame_cnt_q + 8'd1;
            state_d     = enable ? ST_VSYNC : ST_IDLE;
          end
          default:   state_d = ST_IDLE;
        endcase
      end
    end

    // Pattern settings are frozen for the whole frame from its first cycle
    if ((state_d == ST_VSYNC) && (state_q != ST_VSYNC)) begin
      mode_d  = mode_e'(mode);
      solid_d = solid_rgb;
    end
  end

  // Outputs decoded from the current counters, registered next edge
  always_comb begin
    vsync_d       = (state_q == ST_VSYNC);
    href_d        = (state_q == ST_ACTIVE) && (hcnt_q < H_ACT_C);
    frame_start_d = (state_q == ST_VSYNC) && (vcnt_q == '0) && (hcnt_q == '0) && !byte_ph_q;
    data_d        = href_d ? rgb444_byte(pix_rgb, byte_ph_q) : 8'h00;
  end

  assign vsync       = vsync_q;
  assign href        = href_q;
  assign data        = data_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Directed bench for ov7670_stream_gen at shrunken frame timing; pixel bytes
// are checked through a scoreboard queue filled ahead of each frame.
module tb_ov7670_stream_gen;

  localparam int H_ACTIVE = 128;
  localparam int H_TOTAL  = 136;
  localparam int V_SYNC   = 3;
  localparam int V_BP     = 2;
  localparam int V_ACTIVE = 34;
  localparam int V_FP     = 2;
  localparam int LINE     = 2 * H_TOTAL;
  localparam int FRAME    = (V_SYNC + V_BP + V_ACTIVE + V_FP) * LINE;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [11:0] solid_rgb = 12'h000;
  logic        vsync, href, frame_start;
  logic [7:0]  data, frame_cnt;

  ov7670_stream_gen #(
    .H_ACTIVE (H_ACTIVE), .H_TOTAL (H_TOTAL), .V_SYNC (V_SYNC),
    .V_BP (V_BP), .V_ACTIVE (V_ACTIVE), .V_FP (V_FP)
  ) dut (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .enable      (enable),
    .mode        (mode),
    .solid_rgb   (solid_rgb),
    .vsync       (vsync),
    .href        (href),
    .data        (data),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int         fr;
    int         ln;
    int         bi;
    logic [7:0] val;
  } sb_t;
  sb_t sb_q[$];

  task automatic push_pix(input int fr, input int ln, input int x, input logic [11:0] rgb);
    sb_q.push_back('{fr, ln, 2 * x,     {4'h0, rgb[11:8]}});
    sb_q.push_back('{fr, ln, 2 * x + 1, rgb[7:0]});
  endtask

  // Monitor state
  bit  mon_en = 1'b0;
  int  cyc = 0;
  int  frame_idx = -1;
  int  act_line = -1;
  int  byte_idx = 0;
  int  href_len = 0;
  int  rise_cyc = 0;
  int  vs_rises = 0;
  int  fs_err = 0;
  int  data_err = 0;
  logic vsync_p = 1'b0;
  logic href_p = 1'b0;
  sb_t item;

  always @(negedge pclk) begin
    cyc++;
    if (mon_en) begin
      if (vsync && !vsync_p) begin
        frame_idx++;
        vs_rises++;
        if (frame_idx >= 1) begin
          chk($sformatf("lines_f%0d", frame_idx - 1), act_line + 1, V_ACTIVE);
          if (frame_idx <= 3) chk($sformatf("period_f%0d", frame_idx - 1), cyc - rise_cyc, FRAME);
        end
        chk($sformatf("frame_cnt_f%0d", frame_idx), frame_cnt, frame_idx % 256);
        while (sb_q.size() > 0 && sb_q[0].fr < frame_idx) begin
          item = sb_q.pop_front();
          chk($sformatf("missed f%0d y%0d b%0d", item.fr, item.ln, item.bi), item.fr, frame_idx);
        end
        act_line = -1;
        rise_cyc = cyc;
      end
      if (!vsync && vsync_p)
        chk($sformatf("vsync_width_f%0d", frame_idx), cyc - rise_cyc, V_SYNC * LINE);
      if (href && !href_p) begin
        act_line++;
        byte_idx = 0;
        href_len = 0;
        if (act_line == 0)
          chk($sformatf("first_active_f%0d", frame_idx), cyc - rise_cyc, (V_SYNC + V_BP) * LINE);
      end else if (href) begin
        byte_idx++;
      end
      if (href) begin
        href_len++;
        if (sb_q.size() > 0 && sb_q[0].fr == frame_idx && sb_q[0].ln == act_line
            && sb_q[0].bi == byte_idx) begin
          item = sb_q.pop_front();
          chk($sformatf("pix f%0d y%0d b%0d", item.fr, item.ln, item.bi), data, item.val);
        end
      end
      if (!href && href_p)
        chk($sformatf("href_width f%0d y%0d", frame_idx, act_line), href_len, 2 * H_ACTIVE);
      if (!href && data != 8'h00) data_err++;
      if (frame_start !== (vsync && !vsync_p)) fs_err++;
    end
    vsync_p = vsync;
    href_p  = href;
  end

  // Bounded wait for a given active line of a given frame (returns at negedge+1)
  task automatic wait_active_line(input int fr, input int ln);
    bit found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge pclk);
      #1;
      if (frame_idx == fr && act_line == ln && href) found = 1'b1;
    end
    chk($sformatf("reach f%0d y%0d", fr, ln), found, 1'b1);
  endtask

  initial begin
    int nonzero;

    // Reset held low: everything quiet
    repeat (3) @(negedge pclk);
    chk("rst_vsync", vsync, 1'b0);
    chk("rst_href", href, 1'b0);
    chk("rst_data", data, 8'h00);
    chk("rst_frame_start", frame_start, 1'b0);
    chk("rst_frame_cnt", frame_cnt, 8'h00);

    // Released with enable low: stays idle
    rst_n = 1'b1;
    mon_en = 1'b1;
    nonzero = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge pclk);
      #1;
      if (vsync || href || data != 0 || frame_start || frame_cnt != 0) nonzero++;
    end
    chk("idle_outputs_nonzero", nonzero, 0);
    chk("idle_vsync_rises", vs_rises, 0);

    // Frame 0: colour bars
    push_pix(0, 0, 0,   12'hFFF);
    push_pix(0, 0, 16,  12'hFF0);
    push_pix(0, 0, 127, 12'h000);
    push_pix(0, 20, 0,  12'hFFF);
    push_pix(0, 20, 40, 12'h0FF);
    enable = 1'b1;
    @(negedge pclk);
    #1;
    chk("start_vsync_n0", vsync, 1'b0);
    @(negedge pclk);
    #1;
    chk("start_vsync_n1", vsync, 1'b1);
    chk("start_frame_start_n1", frame_start, 1'b1);

    // Mid-frame switch to solid: frame 0 stays bars, frame 1 is solid
    wait_active_line(0, 10);
    mode = 2'd3;
    solid_rgb = 12'hA5C;
    push_pix(1, 0, 0,    12'hA5C);
    push_pix(1, 33, 127, 12'hA5C);

    // Frame 2: checker
    wait_active_line(1, 5);
    mode = 2'd1;
    push_pix(2, 0, 31,  12'h000);
    push_pix(2, 0, 32,  12'hFFF);
    push_pix(2, 32, 0,  12'hFFF);
    push_pix(2, 32, 32, 12'h000);

    // Frame 3: ramp
    wait_active_line(2, 5);
    mode = 2'd2;
    push_pix(3, 0, 63,  12'h000);
    push_pix(3, 0, 64,  12'h111);
    push_pix(3, 3, 127, 12'h111);

    // Drop enable mid-frame 3: frame completes, then idle
    wait_active_line(3, 20);
    enable = 1'b0;
    repeat (FRAME) @(negedge pclk);
    #1;
    chk("drop_frame_cnt", frame_cnt, 8'd4);
    chk("drop_vsync_rises", vs_rises, 4);
    chk("drop_lines_f3", act_line + 1, V_ACTIVE);
    chk("drop_vsync_low", vsync, 1'b0);
    chk("sb_empty", sb_q.size(), 0);
    chk("frame_start_alignment_errs", fs_err, 0);
    chk("data_outside_href_errs", data_err, 0);

    // Restart, then asynchronous reset in the middle of a line
    enable = 1'b1;
    wait_active_line(4, 1);
    mon_en = 1'b0;
    chk("pre_rst_href", href, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_href", href, 1'b0);
    chk("async_rst_data", data, 8'h00);
    chk("async_rst_vsync", vsync, 1'b0);
    chk("async_rst_frame_cnt", frame_cnt, 8'h00);
    enable = 1'b0;
    @(negedge pclk);
    rst_n = 1'b1;
    repeat (3) @(negedge pclk);
    #1;
    chk("post_rst_idle_vsync", vsync, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
